// File: rtl/stoppuhr_lap_mux.sv
// Stopwatch core: DIGITS-digit BCD counter with start/stop/lap control, lap hold,
// sticky overflow and a registered one-digit-at-a-time scan output for a 7-segment decoder.
module stoppuhr_lap_mux #(
   parameter int DIGITS = 4,
   parameter int DP_POS = 2
) (
   input  logic              clk_i,
   input  logic              res_i,
   input  logic              tick_en_i,
   input  logic              scan_en_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic              lap_i,
   output logic [3:0]        digit_o,
   output logic [DIGITS-1:0] dig_sel_o,
   output logic              dp_o,
   output logic              running_o,
   output logic              held_o,
   output logic              ovf_o
);
   localparam int IW = $clog2(DIGITS);

   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

   state_t                  state_q, state_d;
   logic [DIGITS-1:0][3:0]  cnt_q, cnt_d, hold_q, hold_d, src;
   logic                    held_q, held_d, ovf_q, ovf_d, carry;
   logic                    start_q, stop_q, lap_q, start_e, stop_e, lap_e;
   logic [IW-1:0]           idx_q, idx_d;
   logic [3:0]              digit_q;
   logic [DIGITS-1:0]       dig_sel_q;
   logic                    dp_q, running_q;

   // Edge registers always follow the inputs, so a button held through RES yields no edge.
   always_ff @(posedge clk_i) begin
      start_q <= start_i;
      stop_q  <= stop_i;
      lap_q   <= lap_i;
   end

   assign start_e = start_i & ~start_q;
   assign stop_e  = stop_i  & ~stop_q;
   assign lap_e   = lap_i   & ~lap_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      held_d  = held_q;
      ovf_d   = ovf_q;
      carry   = (state_q == RUN) && tick_en_i;
      for (int k = 0; k < DIGITS; k++) begin
         if (carry) begin
            if (cnt_q[k] == 4'd9) begin
               cnt_d[k] = 4'd0;
            end else begin
               cnt_d[k] = cnt_q[k] + 4'd1;
               carry    = 1'b0;
            end
         end
      end
      if (carry) ovf_d = 1'b1;

      case (state_q)
         IDLE: if (start_e && !stop_e) state_d = RUN;
         RUN: begin
            if (stop_e) state_d = STOP;
            if (lap_e) begin
               if (held_q) begin
                  held_d = 1'b0;
               end else begin
                  held_d = 1'b1;
                  hold_d = cnt_q;
               end
            end
         end
         STOP: begin
            if (start_e && !stop_e) state_d = RUN;
            // A clearing lap overrides a coincident resume.
            if (lap_e) begin
               if (held_q) begin
                  held_d = 1'b0;
               end else begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign src   = held_q ? hold_q : cnt_q;
   assign idx_d = !scan_en_i ? idx_q :
                  (idx_q == IW'(DIGITS-1)) ? '0 : idx_q + 1'b1;

   always_ff @(posedge clk_i) begin
      if (res_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hold_q    <= '0;
         held_q    <= 1'b0;
         ovf_q     <= 1'b0;
         idx_q     <= '0;
         digit_q   <= 4'd0;
         dig_sel_q <= DIGITS'(1);
         dp_q      <= (DP_POS == 0);
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         held_q    <= held_d;
         ovf_q     <= ovf_d;
         idx_q     <= idx_d;
         digit_q   <= src[idx_q];
         dig_sel_q <= DIGITS'(1) << idx_q;
         dp_q      <= (idx_q == IW'(DP_POS));
         running_q <= (state_d == RUN);
      end
   end

   assign digit_o   = digit_q;
   assign dig_sel_o = dig_sel_q;
   assign dp_o      = dp_q;
   assign running_o = running_q;
   assign held_o    = held_q;
   assign ovf_o     = ovf_q;
endmodule

// File: tb/tb_stoppuhr_lap_mux.sv
// Bench for stoppuhr_lap_mux: a 4-digit and a 2-digit instance share stimulus and are
// checked every cycle against an integer-arithmetic stopwatch model plus literal expectations.
module tb_stoppuhr_lap_mux;
   logic clk = 1'b0, res = 1'b1, tick = 1'b0, scan = 1'b0;
   logic start = 1'b0, stop = 1'b0, lap = 1'b0;
   logic [3:0] dig4, dig2;
   logic [3:0] sel4;
   logic [1:0] sel2;
   logic dp4, dp2, run4, run2, held4, held2, ovf4, ovf2;

   int passed = 0, total = 0;

   always #5 clk = ~clk;

   stoppuhr_lap_mux #(.DIGITS(4), .DP_POS(2)) dut4 (
      .clk_i(clk), .res_i(res), .tick_en_i(tick), .scan_en_i(scan),
      .start_i(start), .stop_i(stop), .lap_i(lap),
      .digit_o(dig4), .dig_sel_o(sel4), .dp_o(dp4),
      .running_o(run4), .held_o(held4), .ovf_o(ovf4));

   stoppuhr_lap_mux #(.DIGITS(2), .DP_POS(0)) dut2 (
      .clk_i(clk), .res_i(res), .tick_en_i(tick), .scan_en_i(scan),
      .start_i(start), .stop_i(stop), .lap_i(lap),
      .digit_o(dig2), .dig_sel_o(sel2), .dp_o(dp2),
      .running_o(run2), .held_o(held2), .ovf_o(ovf2));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s act=%0d exp=%0d @%0t", nm, act, exp, $time);
      else passed++;
   endtask

   function automatic int p10(input int e);
      int r = 1;
      for (int j = 0; j < e; j++) r *= 10;
      return r;
   endfunction

   // Model: count is a plain integer, state is 0 idle / 1 run / 2 stop.
   localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2;
   int m_st[2], m_cnt[2], m_held[2], m_hold[2], m_ovf[2], m_idx[2];
   int m_dig[2], m_sel[2], m_dp[2], m_run[2];
   int t_src, t_cnt, t_st, t_held, t_hold, t_d, t_p, t_mod;
   bit p_start, p_stop, p_lap, se, pe, le, m_valid = 0;

   always @(posedge clk) begin
      se = start && !p_start;
      pe = stop && !p_stop;
      le = lap && !p_lap;
      for (int i = 0; i < 2; i++) begin
         t_d   = (i == 0) ? 4 : 2;
         t_p   = (i == 0) ? 2 : 0;
         t_mod = p10(t_d);
         if (res) begin
            m_st[i] = M_IDLE; m_cnt[i] = 0; m_held[i] = 0; m_hold[i] = 0;
            m_ovf[i] = 0; m_idx[i] = 0; m_dig[i] = 0; m_sel[i] = 1;
            m_dp[i] = (t_p == 0); m_run[i] = 0;
         end else begin
            t_src    = m_held[i] ? m_hold[i] : m_cnt[i];
            m_dig[i] = (t_src / p10(m_idx[i])) % 10;
            m_sel[i] = 1 << m_idx[i];
            m_dp[i]  = (m_idx[i] == t_p);
            if (scan) m_idx[i] = (m_idx[i] + 1) % t_d;
            t_cnt = m_cnt[i]; t_st = m_st[i]; t_held = m_held[i]; t_hold = m_hold[i];
            if (m_st[i] == M_RUN && tick) begin
               t_cnt = t_cnt + 1;
               if (t_cnt == t_mod) begin t_cnt = 0; m_ovf[i] = 1; end
            end
            if (m_st[i] == M_IDLE) begin
               if (se && !pe) t_st = M_RUN;
            end else if (m_st[i] == M_RUN) begin
               if (pe) t_st = M_STOP;
               if (le) begin
                  if (m_held[i] != 0) t_held = 0;
                  else begin t_held = 1; t_hold = m_cnt[i]; end
               end
            end else begin
               if (se && !pe) t_st = M_RUN;
               if (le) begin
                  if (m_held[i] != 0) t_held = 0;
                  else begin t_cnt = 0; t_st = M_IDLE; end
               end
            end
            m_cnt[i] = t_cnt; m_st[i] = t_st; m_held[i] = t_held; m_hold[i] = t_hold;
            m_run[i] = (t_st == M_RUN);
         end
      end
      p_start = start; p_stop = stop; p_lap = lap;
      if (res) m_valid = 1;
      #1;
      if (m_valid) begin
         chk("dig4", dig4, m_dig[0]);   chk("sel4", sel4, m_sel[0]);
         chk("dp4", dp4, m_dp[0]);      chk("run4", run4, m_run[0]);
         chk("held4", held4, m_held[0]); chk("ovf4", ovf4, m_ovf[0]);
         chk("dig2", dig2, m_dig[1]);   chk("sel2", sel2, m_sel[1]);
         chk("dp2", dp2, m_dp[1]);      chk("run2", run2, m_run[1]);
         chk("held2", held2, m_held[1]); chk("ovf2", ovf2, m_ovf[1]);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      tick = 1'b1;
      cyc(n);
      tick = 1'b0;
   endtask

   // Scan through all positions and rebuild both displayed values from the digit outputs.
   task automatic read_all(output int v4, output int v2);
      int d4[4];
      int d2[2];
      for (int s = 0; s < 4; s++) begin
         for (int k = 0; k < 4; k++) if (sel4[k]) d4[k] = int'(dig4);
         for (int k = 0; k < 2; k++) if (sel2[k]) d2[k] = int'(dig2);
         scan = 1'b1; cyc(1); scan = 1'b0; cyc(1);
      end
      v4 = d4[0] + 10 * d4[1] + 100 * d4[2] + 1000 * d4[3];
      v2 = d2[0] + 10 * d2[1];
   endtask

   int exp_sel[6] = '{2, 4, 8, 1, 2, 4};
   int exp_dp[6]  = '{0, 1, 0, 0, 0, 1};
   int v4, v2;

   initial begin
      cyc(2);
      chk("rst_dig", dig4, 0); chk("rst_sel", sel4, 1); chk("rst_dp", dp4, 0);
      chk("rst_dp2", dp2, 1);  chk("rst_run", run4, 0); chk("rst_held", held4, 0);
      chk("rst_ovf", ovf4, 0);
      res = 1'b0; cyc(1);

      // 1: start, 123 ticks, stop
      start = 1'b1; cyc(1); start = 1'b0;
      ticks(123);
      stop = 1'b1; cyc(1); stop = 1'b0; cyc(2);
      read_all(v4, v2);
      chk("t1_cnt4", v4, 123); chk("t1_cnt2", v2, 23); chk("t1_run", run4, 0);
      chk("t1_ovf2", ovf2, 1); chk("t1_model", m_cnt[0], 123);

      // 2: clear, run to 50, lap hold across 20 ticks, release
      lap = 1'b1; cyc(1); lap = 1'b0;
      start = 1'b1; cyc(1); start = 1'b0;
      ticks(50);
      lap = 1'b1; cyc(1); lap = 1'b0;
      ticks(20); cyc(1);
      read_all(v4, v2);
      chk("t2_hold", v4, 50); chk("t2_held", held4, 1); chk("t2_run", run4, 1);
      lap = 1'b1; cyc(1); lap = 1'b0; cyc(1);
      read_all(v4, v2);
      chk("t2_live", v4, 70); chk("t2_held0", held4, 0);

      // 3: stop, lap clears to idle; start+stop together in RUN stops
      stop = 1'b1; cyc(1); stop = 1'b0;
      lap = 1'b1; cyc(1); lap = 1'b0; cyc(1);
      read_all(v4, v2);
      chk("t3_clr", v4, 0); chk("t3_run", run4, 0);
      start = 1'b1; cyc(1); start = 1'b0;
      ticks(5);
      start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0; cyc(1);
      chk("t3_ss_run", run4, 0);
      read_all(v4, v2);
      chk("t3_ss_cnt", v4, 5);

      // 4: 2-digit wrap at 99 -> 00, overflow survives a lap clear
      res = 1'b1; cyc(1); res = 1'b0;
      start = 1'b1; cyc(1); start = 1'b0;
      ticks(99); cyc(1);
      read_all(v4, v2);
      chk("t4_99", v2, 99); chk("t4_ovf0", ovf2, 0);
      ticks(1); cyc(1);
      read_all(v4, v2);
      chk("t4_00", v2, 0); chk("t4_ovf1", ovf2, 1); chk("t4_cnt4", v4, 100);
      stop = 1'b1; cyc(1); stop = 1'b0;
      lap = 1'b1; cyc(1); lap = 1'b0; cyc(1);
      chk("t4_ovf_kept", ovf2, 1); chk("t4_run", run2, 0);

      // 5: scan sequence after reset
      res = 1'b1; cyc(1); res = 1'b0; cyc(1);
      chk("t5_sel0", sel4, 1);
      for (int s = 0; s < 6; s++) begin
         scan = 1'b1; cyc(1); scan = 1'b0; cyc(1);
         chk("t5_sel", sel4, exp_sel[s]); chk("t5_dp", dp4, exp_dp[s]);
      end

      // 6: reset mid-run, mid-hold with start held high
      start = 1'b1; cyc(1);
      ticks(10);
      lap = 1'b1; cyc(1); lap = 1'b0; cyc(1);
      chk("t6_held_pre", held4, 1); chk("t6_run_pre", run4, 1);
      res = 1'b1; cyc(1); res = 1'b0; cyc(3);
      chk("t6_run", run4, 0); chk("t6_held", held4, 0); chk("t6_dig", dig4, 0);
      chk("t6_sel", sel4, 1); chk("t6_ovf", ovf4, 0);
      start = 1'b0; cyc(2);
      chk("t6_still_idle", run4, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
